wb_stage_param: RTL and testbench

- Parametrised registered writeback unit for the multi-cycle MIPS datapath. It replaces the combinational Readdata/AluResult mux.
- Selects among ALU, memory and link (PC+4) results, and performs byte/halfword load extraction with sign or zero extension.
- Registers the result and issues a single-cycle register-file write strobe on entry to the writeback state.
- Keeps a retired-instruction counter.

---
 rtl/wb_stage_param.sv | 161 ++++++++++++++++
 tb/tb_wb_stage_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_param.sv
// ============================================================================
// Module : wb_stage_param
// Registered writeback: source select, sub-word load extension, RF strobe,
//          retired-instruction counter. Optional forwarding via WB_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage_param #(
   parameter int                 DATA_W     = 32,
   parameter int                 REG_ADDR_W = 5,
   parameter int                 STATE_W    = 6,
   parameter logic [STATE_W-1:0] WB_STATE   = 6'b100000,
   parameter int                 CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [STATE_W-1:0]    state,
   input  logic [DATA_W-1:0]     Readdata,
   input  logic [DATA_W-1:0]     AluResult,
   input  logic [DATA_W-1:0]     PcPlus4,
   input  logic [1:0]            WbSel,
   input  logic [1:0]            LoadSize,
   input  logic                  LoadUnsigned,
   input  logic                  RegWriteEn,
   input  logic [REG_ADDR_W-1:0] DestReg,
   output logic [DATA_W-1:0]     writedata,
   output logic [REG_ADDR_W-1:0] writereg,
   output logic                  regwrite,
   output logic                  wb_done,
   output logic [CNT_W-1:0]      instret
`ifdef WB_BYPASS_EN
   ,
   output logic                  byp_valid,
   output logic [REG_ADDR_W-1:0] byp_reg,
   output logic [DATA_W-1:0]     byp_data
`endif
);

   localparam int OFF_W = $clog2(DATA_W / 8);

   logic                  in_wb_q,     in_wb_d;
   logic [DATA_W-1:0]     writedata_q, writedata_d;
   logic [REG_ADDR_W-1:0] writereg_q,  writereg_d;
   logic                  regwrite_q,  regwrite_d;
   logic                  wb_done_q,   wb_done_d;
   logic [CNT_W-1:0]      instret_q,   instret_d;

   logic                  in_wb;
   logic                  entry;
   logic [OFF_W-1:0]      byte_lane;
   logic [OFF_W-2:0]      half_lane;
   logic [7:0]            byte_val;
   logic [15:0]           half_val;
   logic [DATA_W-1:0]     mem_val;
   logic [DATA_W-1:0]     result;
   logic                  commit;

   always_comb begin
      in_wb     = (state == WB_STATE);
      entry     = in_wb & ~in_wb_q;
      byte_lane = AluResult[OFF_W-1:0];
      half_lane = AluResult[OFF_W-1:1];
      byte_val  = Readdata[{byte_lane, 3'b000} +: 8];
      half_val  = Readdata[{half_lane, 4'b0000} +: 16];

      case (LoadSize)
         2'b10:   mem_val = LoadUnsigned ? {{(DATA_W-8){1'b0}}, byte_val}
                                         : {{(DATA_W-8){byte_val[7]}}, byte_val};
         2'b01:   mem_val = LoadUnsigned ? {{(DATA_W-16){1'b0}}, half_val}
                                         : {{(DATA_W-16){half_val[15]}}, half_val};
         default: mem_val = Readdata;
      endcase

      case (WbSel)
         2'b01:   result = mem_val;
         2'b10:   result = PcPlus4;
         default: result = AluResult;
      endcase

      commit = RegWriteEn & (DestReg != '0);
   end

   // Strobes fall back to 0 every non-entry cycle; data/address hold.
   always_comb begin
      in_wb_d     = in_wb;
      writedata_d = writedata_q;
      writereg_d  = writereg_q;
      regwrite_d  = 1'b0;
      wb_done_d   = 1'b0;
      instret_d   = instret_q;
      if (entry) begin
         writedata_d = result;
         writereg_d  = DestReg;
         regwrite_d  = commit;
         wb_done_d   = 1'b1;
         instret_d   = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_wb_q     <= 1'b0;
         writedata_q <= '0;
         writereg_q  <= '0;
         regwrite_q  <= 1'b0;
         wb_done_q   <= 1'b0;
         instret_q   <= '0;
      end else begin
         in_wb_q     <= in_wb_d;
         writedata_q <= writedata_d;
         writereg_q  <= writereg_d;
         regwrite_q  <= regwrite_d;
         wb_done_q   <= wb_done_d;
         instret_q   <= instret_d;
      end
   end

   assign writedata = writedata_q;
   assign writereg  = writereg_q;
   assign regwrite  = regwrite_q;
   assign wb_done   = wb_done_q;
   assign instret   = instret_q;

`ifdef WB_BYPASS_EN
   logic                  byp_valid_q, byp_valid_d;
   logic [REG_ADDR_W-1:0] byp_reg_q,   byp_reg_d;
   logic [DATA_W-1:0]     byp_data_q,  byp_data_d;

   // Only committed writes are worth forwarding to decode.
   always_comb begin
      byp_valid_d = byp_valid_q;
      byp_reg_d   = byp_reg_q;
      byp_data_d  = byp_data_q;
      if (entry && commit) begin
         byp_valid_d = 1'b1;
         byp_reg_d   = DestReg;
         byp_data_d  = result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byp_valid_q <= 1'b0;
         byp_reg_q   <= '0;
         byp_data_q  <= '0;
      end else begin
         byp_valid_q <= byp_valid_d;
         byp_reg_q   <= byp_reg_d;
         byp_data_q  <= byp_data_d;
      end
   end

   assign byp_valid = byp_valid_q;
   assign byp_reg   = byp_reg_q;
   assign byp_data  = byp_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_param.sv
// ============================================================================
// Module : tb_wb_stage_param
// Scoreboard bench for wb_stage_param (CNT_W=4 so counter wrap is reachable).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_param;

   localparam logic [5:0] WB = 6'b100000;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  state;
   logic [31:0] Readdata, AluResult, PcPlus4;
   logic [1:0]  WbSel, LoadSize;
   logic        LoadUnsigned, RegWriteEn;
   logic [4:0]  DestReg;
   logic [31:0] writedata;
   logic [4:0]  writereg;
   logic        regwrite, wb_done;
   logic [3:0]  instret;
`ifdef WB_BYPASS_EN
   logic        byp_valid;
   logic [4:0]  byp_reg;
   logic [31:0] byp_data;
`endif

   wb_stage_param #(
      .DATA_W(32), .REG_ADDR_W(5), .STATE_W(6), .WB_STATE(WB), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset), .state(state),
      .Readdata(Readdata), .AluResult(AluResult), .PcPlus4(PcPlus4),
      .WbSel(WbSel), .LoadSize(LoadSize), .LoadUnsigned(LoadUnsigned),
      .RegWriteEn(RegWriteEn), .DestReg(DestReg),
      .writedata(writedata), .writereg(writereg), .regwrite(regwrite),
      .wb_done(wb_done), .instret(instret)
`ifdef WB_BYPASS_EN
      , .byp_valid(byp_valid), .byp_reg(byp_reg), .byp_data(byp_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        rw;
      logic [3:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [3:0]  exp_cnt;
   logic [31:0] last_data = '0;
   logic [4:0]  last_reg  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops on every wb_done, otherwise checks strobe/hold behaviour.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (wb_done === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_wb_done", 32'(wb_done), 32'd0);
            end else begin
               e = sb.pop_front();
               check("writedata", writedata, e.data);
               check("writereg", 32'(writereg), 32'(e.rd));
               check("regwrite", 32'(regwrite), 32'(e.rw));
               check("instret", 32'(instret), 32'(e.cnt));
               last_data = e.data;
               last_reg  = e.rd;
            end
         end else begin
            check("regwrite_idle", 32'(regwrite), 32'd0);
            check("writedata_hold", writedata, last_data);
            check("writereg_hold", 32'(writereg), 32'(last_reg));
         end
         if (reset === 1'b1) begin
            last_data = '0;
            last_reg  = '0;
         end
      end
   end

   task automatic idle_inputs();
      state = '0; Readdata = '0; AluResult = '0; PcPlus4 = '0;
      WbSel = 2'b00; LoadSize = 2'b00; LoadUnsigned = 1'b0;
      RegWriteEn = 1'b0; DestReg = '0;
   endtask

   // One writeback visit of 'hold' cycles followed by one non-WB cycle.
   task automatic wb_op(input logic [1:0] sel, input logic [1:0] size, input logic uns,
                        input logic rwe, input logic [4:0] dest, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input int hold, input logic [31:0] exp_data);
      exp_t e;
      @(posedge clk); #1;
      state = WB; WbSel = sel; LoadSize = size; LoadUnsigned = uns;
      RegWriteEn = rwe; DestReg = dest; Readdata = rd; AluResult = alu; PcPlus4 = pc;
      exp_cnt = exp_cnt + 4'd1;
      e.data = exp_data; e.rd = dest; e.rw = rwe && (dest != 5'd0); e.cnt = exp_cnt;
      sb.push_back(e);
      for (int i = 1; i < hold; i++) begin
         @(posedge clk); #1;
         AluResult = ~alu; DestReg = dest ^ 5'h1f; Readdata = ~rd;  // must be ignored
      end
      @(posedge clk); #1;
      state = 6'b000001;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_writedata", writedata, 32'd0);
      check("rst_wb_done", 32'(wb_done), 32'd0);
      check("rst_instret", 32'(instret), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      //     sel    size   uns  rwe  dest   Readdata      AluResult     PcPlus4    hold expected
      wb_op(2'b00, 2'b00, 1'b0, 1'b1, 5'd8, 32'h0,        32'h0000_1234, 32'h0,       3, 32'h0000_1234);
      wb_op(2'b01, 2'b10, 1'b0, 1'b1, 5'd3, 32'h80FF_7F01, 32'h2,       32'h0,       1, 32'hFFFF_FFFF);
      wb_op(2'b01, 2'b10, 1'b0, 1'b1, 5'd3, 32'h80FF_7F01, 32'h3,       32'h0,       2, 32'hFFFF_FF80);
      wb_op(2'b01, 2'b01, 1'b1, 1'b1, 5'd4, 32'h80FF_7F01, 32'h3,       32'h0,       1, 32'h0000_80FF);
      wb_op(2'b10, 2'b00, 1'b0, 1'b1, 5'd0, 32'h0,        32'h0,        32'h0040_0008, 1, 32'h0040_0008);
      wb_op(2'b01, 2'b01, 1'b0, 1'b1, 5'd6, 32'h80FF_7F01, 32'h0,       32'h0,       1, 32'h0000_7F01);
      wb_op(2'b01, 2'b10, 1'b1, 1'b1, 5'd7, 32'h80FF_7F01, 32'h3,       32'h0,       1, 32'h0000_0080);
      wb_op(2'b01, 2'b00, 1'b0, 1'b1, 5'd9, 32'h80FF_7F01, 32'h1,       32'h0,       1, 32'h80FF_7F01);
      wb_op(2'b01, 2'b11, 1'b0, 1'b0, 5'd5, 32'h1234_5678, 32'h2,       32'h0,       1, 32'h1234_5678);
      wb_op(2'b11, 2'b10, 1'b0, 1'b1, 5'd10, 32'hFFFF_FFFF, 32'hABCD_0103, 32'h0,    1, 32'hABCD_0103);

      // Reset asserted in the entry cycle, released while still in WB.
      @(posedge clk); #1;
      state = WB; WbSel = 2'b00; AluResult = 32'h0000_00AA; DestReg = 5'd12;
      RegWriteEn = 1'b1; reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midrst_writedata", writedata, 32'd0);
      check("midrst_regwrite", 32'(regwrite), 32'd0);
      check("midrst_wb_done", 32'(wb_done), 32'd0);
      check("midrst_instret", 32'(instret), 32'd0);
      sb.delete();
      exp_cnt = 4'd1;
      sb.push_back('{data: 32'h0000_00AA, rd: 5'd12, rw: 1'b1, cnt: 4'd1});
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      state = 6'b000011;   // not one-hot: treated as non-WB

      // 15 more entries wrap the 4-bit counter back to 0.
      for (int i = 0; i < 15; i++)
         wb_op(2'b00, 2'b00, 1'b0, (i != 14), 5'(i + 1), 32'h0, 32'(i * 3 + 1), 32'h0, 1, 32'(i * 3 + 1));

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("instret_wrap", 32'(instret), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
`ifdef WB_BYPASS_EN
      check("byp_valid", 32'(byp_valid), 32'd1);
      check("byp_reg", 32'(byp_reg), 32'd14);
      check("byp_data", byp_data, 32'd40);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
